uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Burst controller for the UART receive datapath. It accepts a receive command from a host, configures the receiver's baud and parity, and clears its parity-error status. It then collects a fixed-length burst of 1–32 received bytes into an internal FIFO and streams them to the host over a valid/ready interface, tagging the last byte and each byte's parity status. It sits between the CSR/host logic and the `rx` receiver instance and is the only driver of that receiver's `rx_conf`, `enable` and `clear` inputs.

## Interface
- `CONFIG_WIDTH`, 32: width of `rx_conf`; `rx_enable` and `rx_clear` are `CONFIG_WIDTH/2` wide.
- `FIFO_DEPTH`, 16: byte FIFO entries; must be a power of two, ≥2.
- `TIMEOUT_CYCLES`, 1000000: inter-byte timeout; used only with `UART_RX_CTRL_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_baud`  in  3  baud code 0..7 (1200..115200).
- `cmd_parity_odd`  in  1  1 = odd parity, 0 = even.
- `cmd_parity_en`  in  1  enable parity checking.
- `cmd_len`  in  3  burst length code; length = 2^cmd_len bytes; values >5 clamp to 5 (32 bytes).
- `abort`  in  1  synchronous abort.
- `rx_conf`  out  CONFIG_WIDTH  to receiver.
- `rx_enable`  out  CONFIG_WIDTH/2  to receiver.
- `rx_clear`  out  CONFIG_WIDTH/2  to receiver.
- `rx_dout_valid`  in  1  byte strobe from receiver.
- `rx_dout`  in  8  received byte.
- `rx_error`  in  1  receiver parity error flag.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  host accepts byte.
- `m_data`  out  8  head byte.
- `m_err`  out  1  parity error captured with the head byte.
- `m_last`  out  1  head byte is the final byte of the burst.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `timeout`  out  1  sticky; the burst was ended by the timeout.

## Operation
States:
- IDLE → CLEAR on `cmd_valid & cmd_ready`. The command is latched.
- CLEAR is one cycle and always goes → RECV.
- RECV → DRAIN when the byte count reaches the latched length.
- DRAIN → IDLE when the FIFO is empty; `done` pulses on that transition.
- `abort` in any state: → IDLE next cycle, FIFO flushed, no `done` pulse.

Receiver configuration:
- `rx_conf`: `{13'b0, baud, 15'b0, parity_odd}`, i.e. baud code in bits [18:16] with bits [31:19] zero, parity select in bit 0. Registered on command accept and held until the next accept.
- `rx_clear[6]` and `rx_clear[5:0]` are high only in CLEAR. All other `rx_clear` bits are 0.
- `rx_enable[6]` = `parity_en` in RECV only. All other `rx_enable` bits, including [5:0], are always 0, so the receiver's own byte counting stays inert.

Byte handling:
- In RECV, each `rx_dout_valid` increments a 6-bit byte counter and pushes `{last, rx_error, rx_dout}` into the FIFO. `last` is set when counter+1 equals the length.
- `rx_dout_valid` outside RECV is ignored.
- FIFO full at a push with no simultaneous pop: the byte is dropped, still counted, and `overflow` is set. If the dropped byte is the final one, the burst ends with no `m_last` seen.
- Push and pop in the same cycle while full: both succeed, no overflow.
- `overflow` and `timeout` clear on the next command accept or on `reset`.

## Timing
- Reset values:
  - `cmd_ready` = 1.
  - `rx_conf`, `rx_enable`, `rx_clear`, `m_valid`, `m_data`, `m_err`, `m_last`, `busy`, `done`, `overflow`, `timeout` = 0.
  - FIFO empty, byte counter 0.
- Command accepted at edge T: CLEAR during T+1; RECV and `rx_enable` from T+2.
- Push at edge N: `m_valid` high from N+1. FIFO is show-ahead.
- A pop occurs on `m_valid & m_ready`. `m_data`, `m_err` and `m_last` change only on a pop or a first push.
- DRAIN with the FIFO already empty: IDLE and `done` on the next edge.
- `abort` together with `cmd_valid` in IDLE: the abort wins and the command is not accepted.
- `reset` mid-burst: immediate return to reset values; the partial burst is lost.

## Configuration
- `UART_RX_CTRL_TIMEOUT_EN` defined:
  - A 32-bit counter clears on every `rx_dout_valid` and on entry to RECV, and increments each RECV cycle once the first byte has arrived.
  - Reaching `TIMEOUT_CYCLES` forces → DRAIN and sets `timeout`.
  - No `m_last` is generated for a short burst.
- Undefined: no counter and no such logic; `timeout` is tied to 0 and RECV waits indefinitely.

## Test plan
- Reset, then `cmd_len`=2, `cmd_baud`=7, even parity, `cmd_parity_en`=1 → `rx_conf`=0x0007_0000; `rx_clear`=0x007F for one cycle; `rx_enable`=0x0040.
- With `m_ready`=1, four bytes 0x11, 0x22, 0x33, 0x44 → they appear in order, `m_last` only on 0x44, `done` one cycle after the FIFO drains, `cmd_ready`=1.
- `FIFO_DEPTH`=16, `cmd_len`=5, `m_ready`=0, 17 bytes → `overflow`=1 and 16 bytes held. Then `m_ready`=1 and the remaining 15 bytes → bytes 1–16 and 18–32 are delivered (31 total), 32 marked `m_last`.
- Byte with `rx_error`=1 on the 2nd of 2 bytes → `m_err`=1 only on that byte.
- `abort` after 3 of 8 bytes → IDLE next cycle, `m_valid`=0, no `done`, `rx_enable`=0.
- With `UART_RX_CTRL_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=100: 2 of 4 bytes, then silence → `timeout`=1 and DRAIN after 100 idle cycles, `done` after both bytes are popped.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Burst controller for the UART receiver: configures rx, collects 1..32 bytes into a FIFO, streams them out.
// Optional inter-byte timeout is enabled by defining UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int CONFIG_WIDTH   = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_baud,
  input  logic                      cmd_parity_odd,
  input  logic                      cmd_parity_en,
  input  logic [2:0]                cmd_len,
  input  logic                      abort,
  output logic [CONFIG_WIDTH-1:0]   rx_conf,
  output logic [CONFIG_WIDTH/2-1:0] rx_enable,
  output logic [CONFIG_WIDTH/2-1:0] rx_clear,
  input  logic                      rx_dout_valid,
  input  logic [7:0]                rx_dout,
  input  logic                      rx_error,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [7:0]                m_data,
  output logic                      m_err,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CONFIG_WIDTH / 2;

  typedef enum logic [1:0] {IDLE, CLEAR, RECV, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, busy_q, done_q, overflow_q, pen_q;
  logic [CONFIG_WIDTH-1:0] rx_conf_q;
  logic [EW-1:0]           rx_enable_q, rx_clear_q;
  logic [5:0]              len_q, cnt_q;
  logic [2:0]              len_code;

  logic [9:0]              mem [FIFO_DEPTH];
  logic [9:0]              head_q, push_word;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q;
  logic                    accept, rx_byte, last_byte, full, pop, do_push, tmo_hit;

  assign accept    = (state_q == IDLE) && cmd_valid && !abort;
  assign rx_byte   = (state_q == RECV) && rx_dout_valid && !abort;
  assign last_byte = (cnt_q + 6'd1) == len_q;
  assign full      = count_q == (AW+1)'(FIFO_DEPTH);
  assign pop       = m_valid && m_ready && !abort;
  assign do_push   = rx_byte && (!full || pop);
  assign push_word = {last_byte, rx_error, rx_dout};
  assign len_code  = (cmd_len > 3'd5) ? 3'd5 : cmd_len;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic [31:0] tcnt_q;
  logic        seen_q, timeout_q;

  assign tmo_hit = (state_q == RECV) && seen_q && !rx_dout_valid &&
                   (tcnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  // Idle-gap counter only runs after the first byte of the burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt_q    <= '0;
      seen_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == CLEAR) begin
        tcnt_q <= '0;
        seen_q <= 1'b0;
      end else if (state_q == RECV) begin
        if (rx_dout_valid) begin
          tcnt_q <= '0;
          seen_q <= 1'b1;
        end else if (seen_q) begin
          tcnt_q <= tcnt_q + 32'd1;
        end
      end
      if (accept)
        timeout_q <= 1'b0;
      else if (tmo_hit && !abort)
        timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = CLEAR;
      CLEAR:   state_d = RECV;
      RECV:    if ((rx_dout_valid && last_byte) || tmo_hit) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      pen_q       <= 1'b0;
      rx_conf_q   <= '0;
      rx_enable_q <= '0;
      rx_clear_q  <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_q == DRAIN) && (state_d == IDLE) && !abort;
      rx_clear_q  <= (state_d == CLEAR) ? EW'(7'h7F) : '0;
      rx_enable_q <= '0;
      rx_enable_q[6] <= pen_q && (state_d == RECV);
      if (accept) begin
        rx_conf_q        <= '0;
        rx_conf_q[18:16] <= cmd_baud;
        rx_conf_q[0]     <= cmd_parity_odd;
        pen_q            <= cmd_parity_en;
        len_q            <= 6'd1 << len_code;
        cnt_q            <= '0;
        overflow_q       <= 1'b0;
      end
      if (rx_byte) cnt_q <= cnt_q + 6'd1;
      if (rx_byte && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= push_word;
  end

  // Head register gives show-ahead output that only moves on a pop or a push into an empty FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (pop) begin
        if (count_q > (AW+1)'(1))
          head_q <= mem[rd_ptr_q + AW'(1)];
        else if (do_push)
          head_q <= push_word;
      end else if (do_push && (count_q == '0)) begin
        head_q <= push_word;
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign rx_conf   = rx_conf_q;
  assign rx_enable = rx_enable_q;
  assign rx_clear  = rx_clear_q;
  assign m_valid   = count_q != '0;
  assign m_data    = head_q[7:0];
  assign m_err     = head_q[8];
  assign m_last    = head_q[9];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl: reset, configuration, bursts, overflow, parity flag, abort, reset mid-burst.
module tb_uart_rx_ctrl;

  logic        clock, reset;
  logic        cmd_valid, cmd_ready, cmd_parity_odd, cmd_parity_en, abort;
  logic [2:0]  cmd_baud, cmd_len;
  logic [31:0] rx_conf;
  logic [15:0] rx_enable, rx_clear;
  logic        rx_dout_valid, rx_error;
  logic [7:0]  rx_dout, m_data;
  logic        m_valid, m_ready, m_err, m_last, busy, done, overflow, timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [9:0] got_q[$];

  uart_rx_ctrl #(.CONFIG_WIDTH(32), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_baud(cmd_baud),
    .cmd_parity_odd(cmd_parity_odd), .cmd_parity_en(cmd_parity_en), .cmd_len(cmd_len),
    .abort(abort), .rx_conf(rx_conf), .rx_enable(rx_enable), .rx_clear(rx_clear),
    .rx_dout_valid(rx_dout_valid), .rx_dout(rx_dout), .rx_error(rx_error),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err), .m_last(m_last),
    .busy(busy), .done(done), .overflow(overflow), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && m_valid && m_ready) got_q.push_back({m_last, m_err, m_data});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_dout = b; rx_error = e; rx_dout_valid = 1'b1;
    tick();
    rx_dout_valid = 1'b0; rx_error = 1'b0;
  endtask

  task automatic start_cmd(input logic [2:0] len, input logic [2:0] baud, input logic odd, input logic pen);
    cmd_len = len; cmd_baud = baud; cmd_parity_odd = odd; cmd_parity_en = pen;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if ({busy, done, overflow, timeout, m_valid, m_err, m_last} !== 7'b0) begin errors++; $display("FAIL reset_flags got %b exp 0", {busy, done, overflow, timeout, m_valid, m_err, m_last}); end
    checks++; if (rx_conf !== 32'h0) begin errors++; $display("FAIL reset_rx_conf got %h exp 0", rx_conf); end
    checks++; if ({rx_enable, rx_clear} !== 32'h0) begin errors++; $display("FAIL reset_rx_en_clr got %h exp 0", {rx_enable, rx_clear}); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_config();
    start_cmd(3'd2, 3'd7, 1'b0, 1'b1);
    checks++; if (rx_conf !== 32'h0007_0000) begin errors++; $display("FAIL cfg_rx_conf got %h exp 00070000", rx_conf); end
    checks++; if (rx_clear !== 16'h007F) begin errors++; $display("FAIL cfg_rx_clear got %h exp 007f", rx_clear); end
    checks++; if (rx_enable !== 16'h0000) begin errors++; $display("FAIL cfg_en_in_clear got %h exp 0000", rx_enable); end
    checks++; if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL cfg_busy_ready got %b exp 10", {busy, cmd_ready}); end
    tick();
    checks++; if (rx_clear !== 16'h0000) begin errors++; $display("FAIL cfg_clear_off got %h exp 0000", rx_clear); end
    checks++; if (rx_enable !== 16'h0040) begin errors++; $display("FAIL cfg_rx_enable got %h exp 0040", rx_enable); end
  endtask

  task automatic test_burst4();
    logic [7:0] exp_d [4];
    bit ok;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_byte(exp_d[i], 1'b0);
      tick();
    end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b4_done got none exp pulse"); end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL b4_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4; i++) if (got_q.size() > i) begin
      checks++;
      if (got_q[i] !== {(i == 3), 1'b0, exp_d[i]}) begin errors++; $display("FAIL b4_byte%0d got %h exp %h", i, got_q[i], {(i == 3), 1'b0, exp_d[i]}); end
    end
    checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL b4_idle got %b exp 10", {cmd_ready, busy}); end
    checks++; if (rx_enable !== 16'h0000) begin errors++; $display("FAIL b4_en_off got %h exp 0000", rx_enable); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b4_done_width got %b exp 0", done); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [9:0] exp_w;
    m_ready = 1'b0;
    start_cmd(3'd5, 3'd3, 1'b1, 1'b0);
    tick();
    for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if ({m_valid, m_data} !== {1'b1, 8'h01}) begin errors++; $display("FAIL ovf_head got %b/%h exp 1/01", m_valid, m_data); end
    got_q.delete();
    m_ready = 1'b1;
    for (int i = 18; i <= 32; i++) begin
      send_byte(8'(i), 1'b0);
      tick();
    end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_done got none exp pulse"); end
    checks++; if (got_q.size() !== 31) begin errors++; $display("FAIL ovf_count got %0d exp 31", got_q.size()); end
    for (int j = 0; j < 31; j++) if (got_q.size() > j) begin
      exp_w = {(j == 30), 1'b0, (j < 16) ? 8'(j + 1) : 8'(j + 2)};
      checks++;
      if (got_q[j] !== exp_w) begin errors++; $display("FAIL ovf_byte%0d got %h exp %h", j, got_q[j], exp_w); end
    end
  endtask

  task automatic test_parity_err();
    bit ok;
    start_cmd(3'd1, 3'd0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL par_ovf_cleared got %b exp 0", overflow); end
    tick();
    got_q.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b1);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL par_done got none exp pulse"); end
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL par_count got %0d exp 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 10'h0A5) begin errors++; $display("FAIL par_byte0 got %h exp 0a5", got_q[0]); end
      checks++; if (got_q[1] !== 10'h35A) begin errors++; $display("FAIL par_byte1 got %h exp 35a", got_q[1]); end
    end
  endtask

  task automatic test_abort();
    int d0;
    m_ready = 1'b0;
    start_cmd(3'd3, 3'd1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL abt_pre_valid got %b exp 1", m_valid); end
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, cmd_ready, m_valid} !== 3'b010) begin errors++; $display("FAIL abt_state got %b exp 010", {busy, cmd_ready, m_valid}); end
    checks++; if (rx_enable !== 16'h0000) begin errors++; $display("FAIL abt_en got %h exp 0000", rx_enable); end
    tick(); tick(); tick();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abt_no_done got %0d exp %0d", done_cnt, d0); end
    cmd_valid = 1'b1; abort = 1'b1;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    checks++; if ({busy, cmd_ready, rx_clear} !== {2'b01, 16'h0}) begin errors++; $display("FAIL abt_wins got %b/%b/%h exp 0/1/0000", busy, cmd_ready, rx_clear); end
    send_byte(8'h77, 1'b0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_byte_ignored got %b exp 0", m_valid); end
  endtask

  task automatic test_reset_midburst();
    m_ready = 1'b0;
    start_cmd(3'd2, 3'd5, 1'b1, 1'b1);
    tick();
    send_byte(8'h99, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b exp 1", m_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({m_valid, busy, cmd_ready, m_data} !== {3'b001, 8'h00}) begin errors++; $display("FAIL rst_mid_async got %b%b%b/%h exp 001/00", m_valid, busy, cmd_ready, m_data); end
    checks++; if ({rx_conf, rx_enable} !== 48'h0) begin errors++; $display("FAIL rst_mid_conf got %h exp 0", {rx_conf, rx_enable}); end
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef UART_RX_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n;
    m_ready = 1'b0;
    start_cmd(3'd2, 3'd2, 1'b0, 1'b0);
    tick();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    n = 0;
    while (timeout !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n !== 100) begin errors++; $display("FAIL tmo_cycles got %0d exp 100", n); end
    got_q.delete();
    m_ready = 1'b1;
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_done got none exp pulse"); end
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL tmo_count got %0d exp 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[1] !== 10'h002) begin errors++; $display("FAIL tmo_nolast got %h exp 002", got_q[1]); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_baud = 3'd0; cmd_parity_odd = 1'b0;
    cmd_parity_en = 1'b0; cmd_len = 3'd0; abort = 1'b0;
    rx_dout_valid = 1'b0; rx_dout = 8'h00; rx_error = 1'b0; m_ready = 1'b0;
    test_reset();
    test_config();
    test_burst4();
    test_overflow();
    test_parity_err();
    test_abort();
    test_reset_midburst();
`ifdef UART_RX_CTRL_TIMEOUT_EN
    test_timeout();
`else
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_tied got %b exp 0", timeout); end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
